// File: rtl/oled_fill_sequencer.sv
// oled_fill_sequencer: plays the display init program from ROM, then turns rectangle
// fill requests into window-header and RGB565 pixel byte streams for the display driver.
// Optional feature macro OLED_FILL_SWAP_EN: reversed corners are swapped at latch time.
module oled_fill_sequencer #(
   parameter int WR_HOLD = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic [5:0]  rom_addr,
   input  logic [8:0]  rom_data,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [6:0]  x0,
   input  logic [6:0]  y0,
   input  logic [6:0]  x1,
   input  logic [6:0]  y1,
   input  logic [15:0] color,
   output logic        drv_wr,
   output logic [8:0]  drv_data,
   input  logic        drv_busy,
   output logic        init_done,
   output logic        done
);

   localparam int HW = $clog2(WR_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(WR_HOLD);

   typedef enum logic [1:0] {INIT, IDLE, HEADER, PIXEL} state_t;
   typedef enum logic {ISSUE, WAIT} phase_t;

   state_t        state_q, state_d;
   phase_t        phase_q, phase_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [5:0]    rom_addr_q, rom_addr_d;
   logic          wr_q, wr_d;
   logic [8:0]    data_q, data_d;
   logic          init_done_q, init_done_d;
   logic          done_q, done_d;
   logic [2:0]    hdr_idx_q, hdr_idx_d;
   logic [6:0]    col_q, col_d;
   logic [6:0]    row_q, row_d;
   logic          hi_q, hi_d;
   logic [6:0]    x0_q, x0_d;
   logic [6:0]    y0_q, y0_d;
   logic [6:0]    x1_q, x1_d;
   logic [6:0]    y1_q, y1_d;
   logic [15:0]   color_q, color_d;
   logic [8:0]    cur_byte;

   assign rom_addr  = rom_addr_q;
   assign drv_wr    = wr_q;
   assign drv_data  = data_q;
   assign init_done = init_done_q;
   assign done      = done_q;
   // Masked during the done cycle so ready rises one cycle after the pulse.
   assign req_ready = (state_q == IDLE) && !done_q;

   always_comb begin
      cur_byte = rom_data;
      if (state_q == HEADER) begin
         case (hdr_idx_q)
            3'd0:    cur_byte = 9'h015;
            3'd1:    cur_byte = {2'b10, x0_q};
            3'd2:    cur_byte = {2'b10, x1_q};
            3'd3:    cur_byte = 9'h075;
            3'd4:    cur_byte = {2'b10, y0_q};
            3'd5:    cur_byte = {2'b10, y1_q};
            default: cur_byte = 9'h05C;
         endcase
      end else if (state_q == PIXEL) begin
         cur_byte = {1'b1, hi_q ? color_q[15:8] : color_q[7:0]};
      end
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      hold_d      = hold_q;
      rom_addr_d  = rom_addr_q;
      wr_d        = wr_q;
      data_d      = data_q;
      init_done_d = init_done_q;
      done_d      = 1'b0;
      hdr_idx_d   = hdr_idx_q;
      col_d       = col_q;
      row_d       = row_q;
      hi_d        = hi_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      x1_d        = x1_q;
      y1_d        = y1_q;
      color_d     = color_q;

      if (state_q == IDLE) begin
         if (req_valid && req_ready) begin
            color_d = color;
            phase_d = ISSUE;
`ifdef OLED_FILL_SWAP_EN
            x0_d      = (x0 > x1) ? x1 : x0;
            x1_d      = (x0 > x1) ? x0 : x1;
            y0_d      = (y0 > y1) ? y1 : y0;
            y1_d      = (y0 > y1) ? y0 : y1;
            hdr_idx_d = 3'd0;
            state_d   = HEADER;
`else
            x0_d = x0;
            x1_d = x1;
            y0_d = y0;
            y1_d = y1;
            if ((x0 > x1) || (y0 > y1)) begin
               done_d = 1'b1;
            end else begin
               hdr_idx_d = 3'd0;
               state_d   = HEADER;
            end
`endif
         end
      end else if (phase_q == ISSUE) begin
         if (!wr_q) begin
            // A zero ROM word terminates the init program without being sent.
            if ((state_q == INIT) && (rom_data == 9'h000)) begin
               init_done_d = 1'b1;
               state_d     = IDLE;
            end else begin
               wr_d   = 1'b1;
               data_d = cur_byte;
               hold_d = HW'(1);
            end
         end else if (hold_q == HOLD_LAST) begin
            wr_d    = 1'b0;
            hold_d  = '0;
            phase_d = WAIT;
         end else begin
            hold_d = hold_q + HW'(1);
         end
      end else if (!drv_busy) begin
         phase_d = ISSUE;
         case (state_q)
            INIT: begin
               if (rom_addr_q == 6'd63) begin
                  init_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  rom_addr_d = rom_addr_q + 6'd1;
               end
            end
            HEADER: begin
               if (hdr_idx_q == 3'd6) begin
                  state_d = PIXEL;
                  col_d   = x0_q;
                  row_d   = y0_q;
                  hi_d    = 1'b1;
               end else begin
                  hdr_idx_d = hdr_idx_q + 3'd1;
               end
            end
            PIXEL: begin
               hi_d = ~hi_q;
               if (!hi_q) begin
                  if (col_q == x1_q) begin
                     col_d = x0_q;
                     if (row_q == y1_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                     end else begin
                        row_d = row_q + 7'd1;
                     end
                  end else begin
                     col_d = col_q + 7'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT;
         phase_q     <= ISSUE;
         hold_q      <= '0;
         rom_addr_q  <= '0;
         wr_q        <= 1'b0;
         data_q      <= 9'h000;
         init_done_q <= 1'b0;
         done_q      <= 1'b0;
         hdr_idx_q   <= '0;
         col_q       <= '0;
         row_q       <= '0;
         hi_q        <= 1'b1;
         x0_q        <= '0;
         y0_q        <= '0;
         x1_q        <= '0;
         y1_q        <= '0;
         color_q     <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         hold_q      <= hold_d;
         rom_addr_q  <= rom_addr_d;
         wr_q        <= wr_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
         done_q      <= done_d;
         hdr_idx_q   <= hdr_idx_d;
         col_q       <= col_d;
         row_q       <= row_d;
         hi_q        <= hi_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         x1_q        <= x1_d;
         y1_q        <= y1_d;
         color_q     <= color_d;
      end
   end

endmodule
